sdram_rfsh_sched: RTL and testbench

Auto-refresh scheduler for the SDRAM controller. It runs the refresh-interval timer and tracks postponed refreshes up to a programmable maximum. It arbitrates the SDRAM command bus between the core request path and AUTO REFRESH, issues the refresh command, and enforces the tRFC (trcar_d) recovery window. It sits between the bank/request sequencer and the SDRAM pad command outputs.

---
 rtl/sdram_ctrl_pkg.sv | 19 +
 rtl/sdram_rfsh_timer.sv | 78 +++++++
 rtl/sdram_rfsh_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_rfsh_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM controller: refresh FSM states,
// {ras_n, cas_n, we_n} command encodings and default configuration widths.
package sdram_ctrl_pkg;

    localparam int DEF_RFSH_W  = 12;
    localparam int DEF_RFMAX_W = 3;
    localparam int DEF_TRCAR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        TRFC  = 2'd3
    } rfsh_state_e;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_REF = 3'b001;

endpackage

// File: rtl/sdram_rfsh_timer.sv
// Refresh-interval down-counter with tick generation and the saturating
// count of postponed (pending) refreshes.
module sdram_rfsh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int RFSH_W  = DEF_RFSH_W,
    parameter int RFMAX_W = DEF_RFMAX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic [RFSH_W-1:0]  cfg_rfsh,
    input  logic [RFMAX_W-1:0] cfg_rfmax,
    input  logic               pend_dec,
    output logic [RFMAX_W-1:0] pend
);

    logic [RFSH_W-1:0]  cnt_r;
    logic [RFMAX_W-1:0] pend_r;
    logic               active_s;
    logic               tick_s;

    // Tick fires on the cycle the running counter sits at zero.
    always_comb begin
        active_s = 1'b0;
        tick_s   = 1'b0;
        if (cfg_en && (cfg_rfsh != {RFSH_W{1'b0}})) begin
            active_s = 1'b1;
            tick_s   = (cnt_r == {RFSH_W{1'b0}});
        end else begin
            active_s = 1'b0;
            tick_s   = 1'b0;
        end
    end

    // Interval counter: parked at the reload value while the controller is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {RFSH_W{1'b0}};
        end else if (!cfg_en) begin
            cnt_r <= cfg_rfsh - RFSH_W'(1);
        end else if (!active_s) begin
            cnt_r <= cnt_r;
        end else if (tick_s) begin
            cnt_r <= cfg_rfsh - RFSH_W'(1);
        end else begin
            cnt_r <= cnt_r - RFSH_W'(1);
        end
    end

    // Pending count: a tick landing on an issued refresh cancels out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {RFMAX_W{1'b0}};
        end else begin
            case ({tick_s, pend_dec})
                2'b10: begin
                    if (pend_r < cfg_rfmax) begin
                        pend_r <= pend_r + RFMAX_W'(1);
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                2'b01: begin
                    if (pend_r != {RFMAX_W{1'b0}}) begin
                        pend_r <= pend_r - RFMAX_W'(1);
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                default: pend_r <= pend_r;
            endcase
        end
    end

    assign pend = pend_r;

endmodule

// File: rtl/sdram_rfsh_sched.sv
// Auto-refresh scheduler: arbitrates the command bus between the core and
// AUTO REFRESH and enforces tRFC. SDRAM_RFSH_STATS_EN adds statistics counters.
module sdram_rfsh_sched
    import sdram_ctrl_pkg::*;
#(
    parameter int RFSH_W  = DEF_RFSH_W,
    parameter int RFMAX_W = DEF_RFMAX_W,
    parameter int TRCAR_W = DEF_TRCAR_W
) (
    input  logic               sdram_clk,
    input  logic               sdram_resetn,
    input  logic               cfg_sdr_en,
    input  logic [RFSH_W-1:0]  cfg_sdr_rfsh,
    input  logic [RFMAX_W-1:0] cfg_sdr_rfmax,
    input  logic [TRCAR_W-1:0] cfg_sdr_trcar_d,
    input  logic               core_req,
    output logic               core_gnt,
    input  logic               bank_idle,
    output logic               rfsh_hold,
    output logic               rfsh_busy,
    output logic [RFMAX_W-1:0] rfsh_pend_cnt,
    output logic               rfsh_ras_n,
    output logic               rfsh_cas_n,
    output logic               rfsh_we_n
`ifdef SDRAM_RFSH_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        stat_rfsh_cnt,
    output logic [15:0]        stat_urgent_cnt
`endif
);

    rfsh_state_e        state_r;
    rfsh_state_e        state_next_s;
    logic [RFMAX_W-1:0] pend_s;
    logic               pend_nz_s;
    logic               urgent_s;
    logic               lazy_s;
    logic [TRCAR_W-1:0] trfc_cnt_r;
    logic [TRCAR_W-1:0] trfc_load_s;
    logic               trfc_done_s;
    logic               hold_r;
    logic               hold_next_s;
    logic               busy_r;
    logic [2:0]         cmd_r;
    logic               core_gnt_s;

    sdram_rfsh_timer #(
        .RFSH_W  (RFSH_W),
        .RFMAX_W (RFMAX_W)
    ) u_timer (
        .clk       (sdram_clk),
        .rst_n     (sdram_resetn),
        .cfg_en    (cfg_sdr_en),
        .cfg_rfsh  (cfg_sdr_rfsh),
        .cfg_rfmax (cfg_sdr_rfmax),
        .pend_dec  (state_r == ISSUE),
        .pend      (pend_s)
    );

    // Refresh urgency classification and tRFC load value (zero means one cycle).
    always_comb begin
        pend_nz_s   = (pend_s != {RFMAX_W{1'b0}});
        urgent_s    = pend_nz_s && (pend_s == cfg_sdr_rfmax);
        lazy_s      = pend_nz_s && !urgent_s;
        trfc_done_s = (trfc_cnt_r <= TRCAR_W'(1));
        if (cfg_sdr_trcar_d == {TRCAR_W{1'b0}}) begin
            trfc_load_s = TRCAR_W'(1);
        end else begin
            trfc_load_s = cfg_sdr_trcar_d;
        end
    end

    // FSM state register.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; once a drain has started every pending refresh is flushed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!cfg_sdr_en) begin
                    state_next_s = IDLE;
                end else if (urgent_s) begin
                    state_next_s = DRAIN;
                end else if (lazy_s && !core_req && bank_idle) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                if (!cfg_sdr_en) begin
                    state_next_s = IDLE;
                end else if (bank_idle) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            ISSUE: state_next_s = TRFC;
            TRFC: begin
                if (!trfc_done_s) begin
                    state_next_s = TRFC;
                end else if (cfg_sdr_en && pend_nz_s && (urgent_s || hold_r || !core_req)) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: same-cycle grant plus the next value of the hold flag.
    always_comb begin
        core_gnt_s  = 1'b0;
        hold_next_s = hold_r;
        if (state_r == IDLE) begin
            core_gnt_s = core_req && !urgent_s;
        end else begin
            core_gnt_s = 1'b0;
        end
        if (state_next_s == DRAIN) begin
            hold_next_s = 1'b1;
        end else if (state_next_s == IDLE) begin
            hold_next_s = 1'b0;
        end else begin
            hold_next_s = hold_r;
        end
    end

    // Registered command/status outputs, aligned with the state they describe.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            hold_r <= 1'b0;
            busy_r <= 1'b0;
            cmd_r  <= CMD_NOP;
        end else begin
            hold_r <= hold_next_s;
            busy_r <= (state_next_s == ISSUE) || (state_next_s == TRFC);
            cmd_r  <= (state_next_s == ISSUE) ? CMD_REF : CMD_NOP;
        end
    end

    // tRFC recovery counter, loaded while the command is on the bus.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            trfc_cnt_r <= {TRCAR_W{1'b0}};
        end else if (state_r == ISSUE) begin
            trfc_cnt_r <= trfc_load_s;
        end else if ((state_r == TRFC) && (trfc_cnt_r != {TRCAR_W{1'b0}})) begin
            trfc_cnt_r <= trfc_cnt_r - TRCAR_W'(1);
        end else begin
            trfc_cnt_r <= trfc_cnt_r;
        end
    end

`ifdef SDRAM_RFSH_STATS_EN
    logic [15:0] stat_rfsh_cnt_r;
    logic [15:0] stat_urgent_cnt_r;

    // Statistics: wrapping refresh count, saturating urgent-entry count.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            stat_rfsh_cnt_r   <= 16'h0000;
            stat_urgent_cnt_r <= 16'h0000;
        end else if (stat_clr) begin
            stat_rfsh_cnt_r   <= 16'h0000;
            stat_urgent_cnt_r <= 16'h0000;
        end else begin
            if (state_r == ISSUE) begin
                stat_rfsh_cnt_r <= stat_rfsh_cnt_r + 16'd1;
            end else begin
                stat_rfsh_cnt_r <= stat_rfsh_cnt_r;
            end
            if ((state_r == IDLE) && (state_next_s == DRAIN) && (stat_urgent_cnt_r != 16'hFFFF)) begin
                stat_urgent_cnt_r <= stat_urgent_cnt_r + 16'd1;
            end else begin
                stat_urgent_cnt_r <= stat_urgent_cnt_r;
            end
        end
    end

    assign stat_rfsh_cnt   = stat_rfsh_cnt_r;
    assign stat_urgent_cnt = stat_urgent_cnt_r;
`endif

    assign core_gnt      = core_gnt_s;
    assign rfsh_hold     = hold_r;
    assign rfsh_busy     = busy_r;
    assign rfsh_pend_cnt = pend_s;
    assign rfsh_ras_n    = cmd_r[2];
    assign rfsh_cas_n    = cmd_r[1];
    assign rfsh_we_n     = cmd_r[0];

endmodule

// File: tb/tb_sdram_rfsh_sched.sv
// Directed self-checking bench for sdram_rfsh_sched (default build).
module tb_sdram_rfsh_sched;

    logic        sdram_clk;
    logic        sdram_resetn;
    logic        cfg_sdr_en;
    logic [11:0] cfg_sdr_rfsh;
    logic [2:0]  cfg_sdr_rfmax;
    logic [3:0]  cfg_sdr_trcar_d;
    logic        core_req;
    logic        core_gnt;
    logic        bank_idle;
    logic        rfsh_hold;
    logic        rfsh_busy;
    logic [2:0]  rfsh_pend_cnt;
    logic        rfsh_ras_n;
    logic        rfsh_cas_n;
    logic        rfsh_we_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ref_cnt = 0;
    int ovl   = 0;

    sdram_rfsh_sched dut (
        .sdram_clk       (sdram_clk),
        .sdram_resetn    (sdram_resetn),
        .cfg_sdr_en      (cfg_sdr_en),
        .cfg_sdr_rfsh    (cfg_sdr_rfsh),
        .cfg_sdr_rfmax   (cfg_sdr_rfmax),
        .cfg_sdr_trcar_d (cfg_sdr_trcar_d),
        .core_req        (core_req),
        .core_gnt        (core_gnt),
        .bank_idle       (bank_idle),
        .rfsh_hold       (rfsh_hold),
        .rfsh_busy       (rfsh_busy),
        .rfsh_pend_cnt   (rfsh_pend_cnt),
        .rfsh_ras_n      (rfsh_ras_n),
        .rfsh_cas_n      (rfsh_cas_n),
        .rfsh_we_n       (rfsh_we_n)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    always @(posedge sdram_clk) cyc++;

    always @(negedge sdram_clk) begin
        if (rfsh_ras_n === 1'b0) ref_cnt++;
        if (core_gnt === 1'b1 && rfsh_ras_n === 1'b0) ovl++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge sdram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ref(input int lim, input string tag, output int t);
        int n;
        n = 0;
        while (rfsh_ras_n !== 1'b0 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, 32'(rfsh_ras_n), 32'd0);
        t = cyc;
    endtask

    task automatic wait_hold(input int lim, input logic lvl, input string tag);
        int n;
        n = 0;
        while (rfsh_hold !== lvl && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, 32'(rfsh_hold), 32'(lvl));
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int n;
        n = 0;
        while (rfsh_busy !== 1'b0 && n < lim) begin
            step(1);
            n++;
        end
        chk(tag, 32'(rfsh_busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},  32'(core_gnt), 32'd0);
        chk({tag, "_hold"}, 32'(rfsh_hold), 32'd0);
        chk({tag, "_busy"}, 32'(rfsh_busy), 32'd0);
        chk({tag, "_pend"}, 32'(rfsh_pend_cnt), 32'd0);
        chk({tag, "_cmd"},  32'({rfsh_ras_n, rfsh_cas_n, rfsh_we_n}), 32'd7);
    endtask

    initial begin
        int e0, t1, t2, h, n, k, g, r0, gm;
        int rt[4];

        sdram_resetn    = 1'b0;
        cfg_sdr_en      = 1'b0;
        cfg_sdr_rfsh    = 12'd100;
        cfg_sdr_rfmax   = 3'd4;
        cfg_sdr_trcar_d = 4'd7;
        core_req        = 1'b0;
        bank_idle       = 1'b1;
        step(3);
        chk_reset_vals("rst");

        // Lazy refresh with an idle core
        sdram_resetn = 1'b1;
        step(2);
        cfg_sdr_en = 1'b1;
        e0 = cyc;
        wait_ref(300, "ref1_seen", t1);
        chk("ref1_lat", 32'(t1 - e0), 32'd101);
        chk("ref1_cas", 32'(rfsh_cas_n), 32'd0);
        chk("ref1_we", 32'(rfsh_we_n), 32'd1);
        chk("ref1_gnt", 32'(core_gnt), 32'd0);
        chk("ref1_pend", 32'(rfsh_pend_cnt), 32'd1);
        n = 0;
        while (rfsh_busy === 1'b1 && n < 50) begin
            n++;
            step(1);
        end
        chk("ref1_busy_len", 32'(n), 32'd8);
        chk("ref1_pend_after", 32'(rfsh_pend_cnt), 32'd0);
        chk("lazy_no_hold", 32'(rfsh_hold), 32'd0);
        core_req = 1'b1;
        #1;
        chk("gnt_comb_1", 32'(core_gnt), 32'd1);
        core_req = 1'b0;
        #1;
        chk("gnt_comb_0", 32'(core_gnt), 32'd0);
        wait_ref(200, "ref2_seen", t2);
        chk("ref_interval", 32'(t2 - t1), 32'd100);
        wait_idle(20, "ref2_done");

        // Busy core: four postponed refreshes, then a forced drain
        core_req = 1'b1;
        wait_hold(600, 1'b1, "urgent_hold");
        chk("urgent_time", 32'(cyc - t2), 32'd400);
        chk("urgent_pend", 32'(rfsh_pend_cnt), 32'd4);
        chk("urgent_gnt", 32'(core_gnt), 32'd0);
        n = 0; k = 0; g = 0;
        while (rfsh_hold === 1'b1 && n < 100) begin
            step(1);
            n++;
            if (rfsh_ras_n === 1'b0 && k < 4) begin
                rt[k] = cyc;
                k++;
            end
            if (rfsh_hold === 1'b1 && core_gnt === 1'b1) g = 1;
        end
        chk("flush_refs", 32'(k), 32'd4);
        chk("flush_first", 32'(rt[0] - t2), 32'd401);
        chk("flush_gap01", 32'(rt[1] - rt[0]), 32'd8);
        chk("flush_gap23", 32'(rt[3] - rt[2]), 32'd8);
        chk("flush_end", 32'(cyc - t2), 32'd433);
        chk("flush_no_gnt", 32'(g), 32'd0);
        chk("flush_pend", 32'(rfsh_pend_cnt), 32'd0);
        chk("flush_gnt_back", 32'(core_gnt), 32'd1);

        // Urgent while banks are busy: stay in drain
        bank_idle = 1'b0;
        wait_hold(500, 1'b1, "drain_hold");
        h = cyc;
        chk("drain_time", 32'(h - t2), 32'd800);
        r0 = ref_cnt;
        step(20);
        chk("drain_no_ref", 32'(ref_cnt - r0), 32'd0);
        chk("drain_hold_kept", 32'(rfsh_hold), 32'd1);
        bank_idle = 1'b1;
        step(1);
        chk("drain_ref", 32'(rfsh_ras_n), 32'd0);
        wait_hold(100, 1'b0, "drain_done");
        chk("drain_pend", 32'(rfsh_pend_cnt), 32'd0);

        // Refresh disabled: core grant follows request
        cfg_sdr_rfsh = 12'd0;
        r0 = ref_cnt;
        gm = 0;
        for (int i = 0; i < 1000; i++) begin
            core_req = 1'((i >> 2) & 1);
            #1;
            if (core_gnt !== core_req) gm++;
            step(1);
        end
        chk("dis_gnt_track", 32'(gm), 32'd0);
        chk("dis_no_ref", 32'(ref_cnt - r0), 32'd0);
        chk("dis_pend", 32'(rfsh_pend_cnt), 32'd0);

        // Reset in the middle of tRFC
        core_req = 1'b0;
        cfg_sdr_rfsh = 12'd100;
        wait_ref(300, "pre_rst_ref", t1);
        step(3);
        chk("pre_rst_busy", 32'(rfsh_busy), 32'd1);
        sdram_resetn = 1'b0;
        cfg_sdr_en = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        step(2);
        sdram_resetn = 1'b1;
        step(2);
        cfg_sdr_en = 1'b1;
        e0 = cyc;
        wait_ref(300, "post_rst_ref", t1);
        chk("post_rst_lat", 32'(t1 - e0), 32'd101);
        wait_idle(20, "post_rst_done");

        // Short interval, rfmax=1, trcar_d=0
        cfg_sdr_en = 1'b0;
        cfg_sdr_rfsh = 12'd5;
        cfg_sdr_rfmax = 3'd1;
        cfg_sdr_trcar_d = 4'd0;
        step(2);
        cfg_sdr_en = 1'b1;
        wait_ref(20, "s_ref1", t1);
        n = 0;
        while (rfsh_busy === 1'b1 && n < 10) begin
            n++;
            step(1);
        end
        chk("s_busy_len", 32'(n), 32'd2);
        wait_ref(20, "s_ref2", t2);
        chk("s_interval", 32'(t2 - t1), 32'd5);
        bank_idle = 1'b0;
        step(3);
        chk("col_pend_tick", 32'(rfsh_pend_cnt), 32'd1);
        chk("col_idle", 32'(rfsh_hold), 32'd0);
        step(1);
        chk("col_drain", 32'(rfsh_hold), 32'd1);
        step(7);
        chk("col_no_ref", 32'(rfsh_ras_n), 32'd1);
        bank_idle = 1'b1;
        step(1);
        chk("col_issue", 32'(rfsh_ras_n), 32'd0);
        chk("col_issue_pend", 32'(rfsh_pend_cnt), 32'd1);
        step(1);
        chk("col_pend_kept", 32'(rfsh_pend_cnt), 32'd1);
        chk("col_trfc_busy", 32'(rfsh_busy), 32'd1);
        chk("col_trfc_nop", 32'(rfsh_ras_n), 32'd1);
        step(1);
        chk("col_b2b_ref", 32'(rfsh_ras_n), 32'd0);

        chk("gnt_ref_overlap", 32'(ovl), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
